// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the write-back cache controller.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWriteback,
        StFill
    } state_e;

    // Widest way vector the helpers accept.
    localparam int unsigned MaxWays = 32;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lowest_set_idx(input logic [MaxWays-1:0] v);
        int unsigned      idx;
        logic [MaxWays-1:0] sh;
        idx = 0;
        for (int i = MaxWays - 1; i >= 0; i--) begin
            sh = v >> i;
            if (sh[0]) idx = unsigned'(i);
        end
        return idx;
    endfunction

    // Index of a one-hot vector; 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [MaxWays-1:0] v);
        int unsigned      idx;
        logic [MaxWays-1:0] sh;
        idx = 0;
        for (int i = 0; i < MaxWays; i++) begin
            sh = v >> i;
            if (sh[0]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state with a combinational victim lookup.
module plru_array #(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned NUM_SETS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [$clog2(NUM_SETS)-1:0] set_i,
    input  logic                        upd_en_i,
    input  logic [$clog2(NUM_WAYS)-1:0] upd_way_i,
    output logic [$clog2(NUM_WAYS)-1:0] victim_o
);

    localparam int unsigned IdxW  = $clog2(NUM_WAYS);
    localparam int unsigned NodeW = NUM_WAYS - 1;

    // Heap layout: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
    logic [NUM_SETS-1:0][NodeW-1:0] tree_q, tree_d;

    // Follow the node bits from the root to the victim leaf.
    always_comb begin
        logic [NodeW-1:0] nodes;
        logic [NodeW-1:0] sh;
        int unsigned      node;
        nodes = tree_q[set_i];
        node  = 0;
        for (int l = 0; l < IdxW; l++) begin
            sh   = nodes >> node;
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        victim_o = IdxW'(node - NodeW);
    end

    // Point every node on the accessed way's path away from that way.
    always_comb begin
        logic [NodeW-1:0] nodes;
        logic [IdxW-1:0]  wsh;
        int unsigned      node;
        logic             dir;
        tree_d = tree_q;
        nodes  = tree_q[set_i];
        node   = 0;
        for (int l = 0; l < IdxW; l++) begin
            wsh   = upd_way_i >> (IdxW - 1 - l);
            dir   = wsh[0];
            nodes = (nodes & ~(NodeW'(1) << node)) | (NodeW'(!dir) << node);
            node  = 2 * node + 1 + (dir ? 1 : 0);
        end
        if (upd_en_i) tree_d[set_i] = nodes;
    end

    // Replacement state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tree_q <= '0;
        else         tree_q <= tree_d;
    end

endmodule

// File: rtl/cache_control_wb.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
module cache_control_wb
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned NUM_SETS  = 8,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [$clog2(NUM_SETS)-1:0] set_idx,
    input  logic [NUM_WAYS-1:0]         way_hit,
    input  logic [NUM_WAYS-1:0]         way_valid,
    input  logic [NUM_WAYS-1:0]         way_dirty,
    input  logic                        pmem_resp,
    output logic                        mem_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [NUM_WAYS-1:0]         way_sel,
    output logic                        load_mem_rdata,
    output logic                        load_data,
    output logic                        data_src_mem,
    output logic                        load_tag,
    output logic                        set_valid,
    output logic                        set_dirty,
    output logic                        clr_dirty,
    output logic                        pmem_addr_victim,
    output logic [CNT_WIDTH-1:0]        hit_count,
    output logic [CNT_WIDTH-1:0]        miss_count
);

    localparam int unsigned IdxW = $clog2(NUM_WAYS);

    state_e               state_q, state_d;
    logic [NUM_WAYS-1:0]  victim_q, victim_d;
    logic                 first_check_q, first_check_d;
    logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

    logic                 req;
    logic                 hit;
    logic [NUM_WAYS-1:0]  invalid_ways;
    logic [IdxW-1:0]      hit_idx;
    logic [IdxW-1:0]      invalid_idx;
    logic [IdxW-1:0]      miss_idx;
    logic [IdxW-1:0]      plru_victim;
    logic                 plru_upd_en;

    assign req          = mem_read | mem_write;
    assign hit          = |way_hit;
    assign invalid_ways = ~way_valid;
    assign hit_idx      = IdxW'(lowest_set_idx(MaxWays'(way_hit)));
    assign invalid_idx  = IdxW'(lowest_set_idx(MaxWays'(invalid_ways)));
    // Empty ways are always filled before anything is evicted.
    assign miss_idx     = (|invalid_ways) ? invalid_idx : plru_victim;

    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

    plru_array #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_plru (
        .clk_i     (clk),
        .rst_ni    (rst),
        .set_i     (set_idx),
        .upd_en_i  (plru_upd_en),
        .upd_way_i (hit_idx),
        .victim_o  (plru_victim)
    );

    // Next state, datapath strobes and statistics from the current state.
    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        first_check_d    = first_check_q;
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;
        plru_upd_en      = 1'b0;
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        way_sel          = '0;
        load_mem_rdata   = 1'b0;
        load_data        = 1'b0;
        data_src_mem     = 1'b0;
        load_tag         = 1'b0;
        set_valid        = 1'b0;
        set_dirty        = 1'b0;
        clr_dirty        = 1'b0;
        pmem_addr_victim = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) state_d = StCheck;
            end
            StCheck: begin
                if (!req) begin
                    // Request withdrawn during a miss: drop it silently.
                    first_check_d = 1'b1;
                    state_d       = StIdle;
                end else if (hit) begin
                    mem_resp    = 1'b1;
                    way_sel     = NUM_WAYS'(1) << hit_idx;
                    plru_upd_en = 1'b1;
                    if (mem_read) begin
                        load_mem_rdata = 1'b1;
                    end else begin
                        load_data = 1'b1;
                        set_dirty = 1'b1;
                    end
                    // The re-check after a fill is not a genuine hit.
                    if (first_check_q && (hit_count_q != '1)) begin
                        hit_count_d = hit_count_q + CNT_WIDTH'(1);
                    end
                    first_check_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    victim_d      = NUM_WAYS'(1) << miss_idx;
                    first_check_d = 1'b0;
                    if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    if (way_valid[miss_idx] && way_dirty[miss_idx]) state_d = StWriteback;
                    else                                            state_d = StFill;
                end
            end
            StWriteback: begin
                pmem_write       = 1'b1;
                pmem_addr_victim = 1'b1;
                way_sel          = victim_q;
                if (pmem_resp) begin
                    clr_dirty = 1'b1;
                    state_d   = StFill;
                end
            end
            StFill: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    load_data    = 1'b1;
                    data_src_mem = 1'b1;
                    load_tag     = 1'b1;
                    set_valid    = 1'b1;
                    clr_dirty    = 1'b1;
                    state_d      = StCheck;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state, victim and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            victim_q      <= '0;
            first_check_q <= 1'b1;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            victim_q      <= victim_d;
            first_check_q <= first_check_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

endmodule
